// File: rtl/fpu_pkg.sv
// Shared FP32 constants, result-flag type and classifier for the add/sub datapath.
package fpu_pkg;

    localparam int unsigned FP_WIDTH         = 32;
    localparam int unsigned FP_EXP_BITS      = 8;
    localparam int unsigned FP_MANT_BITS     = 23;
    localparam int unsigned RSLT_DLY_DEFAULT = 5;

    localparam logic [FP_WIDTH-1:0] POS_INF  = 32'h7F80_0000;
    localparam logic [FP_WIDTH-1:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [FP_WIDTH-1:0] POS_ZERO = 32'h0000_0000;
    localparam logic [FP_WIDTH-1:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [FP_WIDTH-1:0] CAN_NAN  = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } fp_flags_t;

    // Exactly one of the four classes (or none, for a normal number) is reported.
    function automatic fp_flags_t fp_classify(input logic [FP_WIDTH-1:0] v);
        fp_flags_t                 f;
        logic [FP_EXP_BITS-1:0]    e;
        logic [FP_MANT_BITS-1:0]   m;
        e           = v[FP_WIDTH-2:FP_MANT_BITS];
        m           = v[FP_MANT_BITS-1:0];
        f.nan       = (&e) & (|m);
        f.inf       = (&e) & ~(|m);
        f.zero      = ~(|e) & ~(|m);
        f.subnormal = ~(|e) & (|m);
        return f;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data whenever count != 0.
module fpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

endmodule

// File: rtl/add_sub_result_queue.sv
// Captures add_sub_main results RSLT_DLY cycles after each accepted issue, classifies
// them and buffers them; issue credits guarantee the buffer never overflows.
module add_sub_result_queue
    import fpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int RSLT_DLY  = RSLT_DLY_DEFAULT,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         issue_valid,
    input  logic                         issue_op,
    output logic                         issue_ready,
    input  logic [WIDTH-1:0]             R,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH-1:0]             res_data,
    output logic                         res_op,
    output logic [3:0]                   res_flags,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int FLAG_W  = $bits(fp_flags_t);
    localparam int ENTRY_W = WIDTH + 1 + FLAG_W;

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [RSLT_DLY-1:0]    pipe_vld;
    logic [RSLT_DLY-1:0]    pipe_op;
    logic [CNT_W-1:0]       occ_q;
    logic [CNT_W-1:0]       fifo_count;
    logic [EXP_BITS-1:0]    r_exp;
    logic [MANT_BITS-1:0]   r_man;
    fp_flags_t              r_flags;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;

    assign issue_ready = ~arst & (occ_q < CNT_W'(DEPTH));
    assign accept      = issue_valid & issue_ready;

    // The adder cannot stall, so the tracker shifts every cycle regardless of the FIFO.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pipe_vld <= '0;
            pipe_op  <= '0;
        end else begin
            pipe_vld[0] <= accept;
            pipe_op[0]  <= issue_op;
            for (int i = 1; i < RSLT_DLY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_op[i]  <= pipe_op[i-1];
            end
        end
    end

    assign r_exp = R[MANT_BITS +: EXP_BITS];
    assign r_man = R[MANT_BITS-1:0];

    always_comb begin
        r_flags           = '0;
        r_flags.nan       = (&r_exp) & (|r_man);
        r_flags.inf       = (&r_exp) & ~(|r_man);
        r_flags.zero      = ~(|r_exp) & ~(|r_man);
        r_flags.subnormal = ~(|r_exp) & (|r_man);
    end

    assign push       = pipe_vld[RSLT_DLY-1];
    assign push_entry = {R, pipe_op[RSLT_DLY-1], r_flags};
    assign pop        = res_valid & res_ready;

    fpu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count)
    );

    // Credits cover both in-flight and buffered results.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) occ_q <= '0;
        else      occ_q <= occ_q + CNT_W'(accept) - CNT_W'(pop);
    end

    // Stale memory behind an empty FIFO is masked so idle outputs read as zero.
    assign res_valid = (fifo_count != '0);
    assign res_data  = res_valid ? head_entry[ENTRY_W-1 -: WIDTH] : '0;
    assign res_op    = res_valid ? head_entry[FLAG_W]             : 1'b0;
    assign res_flags = res_valid ? head_entry[FLAG_W-1:0]         : 4'b0000;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_add_sub_result_queue.sv
// Self-checking bench for add_sub_result_queue against a queue-based reference model.
module tb_add_sub_result_queue;

    localparam int WIDTH    = 32;
    localparam int RSLT_DLY = 5;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               arst;
    logic               issue_valid;
    logic               issue_op;
    logic               issue_ready;
    logic [WIDTH-1:0]   R;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic               res_op;
    logic [3:0]         res_flags;
    logic [CNT_W-1:0]   occupancy;

    add_sub_result_queue #(
        .WIDTH(WIDTH), .EXP_BITS(8), .MANT_BITS(23), .RSLT_DLY(RSLT_DLY), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst(arst), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_ready(issue_ready), .R(R), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_flags(res_flags), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit op; } issue_t;
    typedef struct { logic [31:0] data; bit op; } res_t;

    issue_t inflight[$];
    res_t   outq[$];
    int     cyc;
    int     n_cmp;
    int     n_err;

    function automatic logic [3:0] ref_flags(input logic [31:0] v);
        int unsigned e;
        int unsigned m;
        e = (v >> 23) & 32'hFF;
        m = v & 32'h007F_FFFF;
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle against the model, advance the model.
    task automatic step(input bit iv, input bit op, input logic [31:0] r, input bit rr);
        bit   exp_ready;
        bit   acc;
        bit   popm;
        int   occ_m;
        res_t ent;
        issue_t iss;
        issue_valid = iv; issue_op = op; R = r; res_ready = rr;
        @(negedge clk);
        occ_m     = inflight.size() + outq.size();
        exp_ready = (occ_m < DEPTH);
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("occupancy", 32'(occupancy), 32'(occ_m));
        chk("res_valid", 32'(res_valid), 32'(outq.size() != 0));
        if (outq.size() != 0) begin
            chk("res_data", res_data, outq[0].data);
            chk("res_op", 32'(res_op), 32'(outq[0].op));
            chk("res_flags", 32'(res_flags), 32'(ref_flags(outq[0].data)));
        end
        acc  = iv && exp_ready;
        popm = (outq.size() != 0) && rr;
        if (popm) void'(outq.pop_front());
        if (inflight.size() != 0 && inflight[0].cyc + RSLT_DLY == cyc) begin
            ent.data = r;
            ent.op   = inflight[0].op;
            outq.push_back(ent);
            void'(inflight.pop_front());
        end
        if (acc) begin
            iss.cyc = cyc;
            iss.op  = op;
            inflight.push_back(iss);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle();
        arst = 1'b1; issue_valid = 1'b1; issue_op = 1'b1; R = $urandom; res_ready = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_op", 32'(res_op), 0);
        chk("rst_res_flags", 32'(res_flags), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        inflight.delete();
        outq.delete();
        cyc++;
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    initial begin
        logic [31:0] sp [4];
        sp[0] = 32'h7FC0_0000; sp[1] = 32'hFF80_0000; sp[2] = 32'h8000_0000; sp[3] = 32'h0000_0001;
        n_cmp = 0; n_err = 0; cyc = 0;
        arst = 1'b1; issue_valid = 1'b0; issue_op = 1'b0; R = '0; res_ready = 1'b0;
        reset_cycle();

        // single add, result 1.0+2.0 on the adder bus five cycles after issue
        for (int k = 0; k < 8; k++)
            step(k == 0, 1'b0, (k == 5) ? 32'h4040_0000 : $urandom, 1'b0);
        chk("add_data", res_data, 32'h4040_0000);
        chk("add_flags", 32'(res_flags), 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, $urandom, 1'b1);

        // back-pressure: consumer stalled, issue held
        for (int k = 0; k < 10; k++) step(1'b1, k[0], $urandom, 1'b0);
        chk("bp_occ_full", 32'(occupancy), DEPTH);
        chk("bp_ready_low", 32'(issue_ready), 0);
        step(1'b1, 1'b0, $urandom, 1'b1);
        chk("bp_ready_after_pop", 32'(issue_ready), 1);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, $urandom, 1'b1);

        // special results on consecutive accepts
        for (int k = 0; k < 12; k++)
            step(k < 4, k[0], (k >= 5 && k < 9) ? sp[k-5] : $urandom, 1'b1);

        // streaming with a running counter on R
        for (int k = 0; k < 20; k++) step(1'b1, k[1], 32'(k), 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'(100 + k), 1'b1);

        // reset mid-flight, then a fresh accept
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, $urandom, 1'b1);
        reset_cycle();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, $urandom, 1'b1);
        chk("rst_no_stale", 32'(res_valid), 0);
        for (int k = 0; k < 8; k++) step(k == 0, 1'b1, $urandom, 1'b1);

        // push and pop in the same cycle with one entry buffered
        for (int k = 0; k < 10; k++) step(k < 2, k[0], $urandom, k == 6);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, $urandom, 1'b1);

        // random mix
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : $urandom,
                 $urandom_range(0, 2) != 0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, $urandom, 1'b1);
        chk("final_empty", 32'(res_valid), 0);
        chk("final_occ", 32'(occupancy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
